// File: rtl/seg_display_pkg.sv
// Shared definitions for the seven-segment display path: segment bit order,
// the hex glyph table and the decode helper used by every display instance.
package seg_display_pkg;

  localparam int SEG_W = 7;

  // Segment bit positions inside the {g,f,e,d,c,b,a} output vector.
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Active-high glyphs, entry k at bits [7k+6:7k]; entry 0 in the low bits.
  localparam logic [16*SEG_W-1:0] HEX_SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
    7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
  };

  function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] hex,
                                                  input logic       active_low);
    logic [SEG_W-1:0] pattern;
    pattern = HEX_SEG_TABLE[int'(hex)*SEG_W +: SEG_W];
    return active_low ? ~pattern : pattern;
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex-to-seven-segment decoder with selectable output polarity.
module seg_hex_decoder
  import seg_display_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0]       hex_i,
  output logic [SEG_W-1:0] seg_o
);

  assign seg_o = seg_decode(hex_i, ACTIVE_LOW);

endmodule

// File: rtl/seg_display_mux.sv
// N-digit multiplexed seven-segment driver with frame-latched inputs,
// anti-ghosting dead time, PWM brightness and per-digit blink.
module seg_display_mux
  import seg_display_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int REFRESH_DIV      = 100000,
  parameter int DEAD_CYCLES      = 500,
  parameter int BRIGHT_W         = 3,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    blink_tick,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [SEG_W-1:0]        seg,
  output logic                    frame_start
);

  localparam int CNT_W = $clog2(REFRESH_DIV + 1);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW    = CNT_W + BRIGHT_W;

  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW}};
  localparam logic [SEG_W-1:0]      SEG_OFF   = {SEG_W{SEG_ACTIVE_LOW}};

  logic [CNT_W-1:0]        slot_cnt_q;
  logic [IDX_W-1:0]        digit_idx_q;
  logic                    blink_phase_q;
  logic                    frame_start_q;
  logic [4*NUM_DIGITS-1:0] digits_l_q;
  logic [NUM_DIGITS-1:0]   en_l_q;
  logic [NUM_DIGITS-1:0]   blink_l_q;
  logic [BRIGHT_W-1:0]     bright_l_q;
  logic [NUM_DIGITS-1:0]   anode_q;
  logic [SEG_W-1:0]        seg_q;

  logic [NUM_DIGITS-1:0]   anode_d;
  logic [SEG_W-1:0]        seg_d;
  logic [NUM_DIGITS-1:0]   anode_onehot;
  logic                    slot_wrap;
  logic                    frame_wrap;
  logic                    lit;
  logic [PW-1:0]           pwm_prod;
  logic [CNT_W-1:0]        on_limit;
  logic [3:0]              cur_hex;
  logic [SEG_W-1:0]        cur_seg;
  logic [3:0]              hex_l [NUM_DIGITS];

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_unpack
    assign hex_l[gi] = digits_l_q[4*gi +: 4];
  end

  assign cur_hex = hex_l[digit_idx_q];

  seg_hex_decoder #(
    .ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) u_hex_decoder (
    .hex_i(cur_hex),
    .seg_o(cur_seg)
  );

  assign slot_wrap  = (slot_cnt_q == CNT_W'(REFRESH_DIV - 1));
  assign frame_wrap = slot_wrap && (digit_idx_q == IDX_W'(NUM_DIGITS - 1));

  // Product is kept at full width so the fraction is taken after the multiply.
  always_comb begin
    pwm_prod = PW'(REFRESH_DIV - DEAD_CYCLES) * PW'(bright_l_q);
    if (bright_l_q == '0) begin
      on_limit = CNT_W'(DEAD_CYCLES);
    end else if (&bright_l_q) begin
      on_limit = CNT_W'(REFRESH_DIV);
    end else begin
      on_limit = CNT_W'(DEAD_CYCLES) + CNT_W'(pwm_prod >> BRIGHT_W);
    end
  end

  assign lit = (slot_cnt_q >= CNT_W'(DEAD_CYCLES)) && (slot_cnt_q < on_limit) &&
               en_l_q[digit_idx_q] && !(blink_phase_q && blink_l_q[digit_idx_q]);

  always_comb begin
    anode_onehot              = '0;
    anode_onehot[digit_idx_q] = 1'b1;
    anode_d = lit ? (anode_onehot ^ ANODE_OFF) : ANODE_OFF;
    seg_d   = lit ? cur_seg : SEG_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q    <= '0;
      digit_idx_q   <= '0;
      blink_phase_q <= 1'b0;
      frame_start_q <= 1'b0;
      digits_l_q    <= '0;
      en_l_q        <= '0;
      blink_l_q     <= '0;
      bright_l_q    <= '0;
      anode_q       <= ANODE_OFF;
      seg_q         <= SEG_OFF;
    end else begin
      anode_q       <= anode_d;
      seg_q         <= seg_d;
      frame_start_q <= frame_wrap;
      if (blink_tick) begin
        blink_phase_q <= ~blink_phase_q;
      end
      if (slot_wrap) begin
        slot_cnt_q  <= '0;
        digit_idx_q <= (digit_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx_q + 1'b1;
      end else begin
        slot_cnt_q  <= slot_cnt_q + 1'b1;
      end
      // Inputs are sampled only when entering slot 0 so a frame never tears.
      if (frame_wrap) begin
        digits_l_q <= digits;
        en_l_q     <= digit_en;
        blink_l_q  <= blink_en;
        bright_l_q <= brightness;
      end
    end
  end

  assign anode       = anode_q;
  assign seg         = seg_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// Self-checking bench for seg_display_mux: cycle-level scoreboard against a
// time-indexed reference model, table-driven frames and hand-written corners.
module tb_seg_display_mux;

  localparam int N  = 4;
  localparam int R  = 8;
  localparam int D  = 1;
  localparam int BW = 2;
  localparam int FRAME = N * R;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] digits = '0;
  logic [3:0]  digit_en = '0;
  logic [3:0]  blink_en = '0;
  logic        blink_tick = 1'b0;
  logic [1:0]  brightness = '0;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        frame_start;

  always #5 clk = ~clk;

  seg_display_mux #(
    .NUM_DIGITS(N),
    .REFRESH_DIV(R),
    .DEAD_CYCLES(D),
    .BRIGHT_W(BW),
    .ANODE_ACTIVE_LOW(1'b1),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .digits(digits),
    .digit_en(digit_en),
    .blink_en(blink_en),
    .blink_tick(blink_tick),
    .brightness(brightness),
    .anode(anode),
    .seg(seg),
    .frame_start(frame_start)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] sg;
    logic       fs;
  } obs_t;

  typedef struct {
    logic [15:0] dg;
    logic [3:0]  en;
    logic [1:0]  br;
    int          exp_lit;
  } vec_t;

  obs_t        sb_q[$];
  obs_t        last;
  int          total = 0;
  int          bad = 0;
  int          lit_cnt = 0;
  int          fs_cnt = 0;

  // Reference model state: t counts cycles since reset release.
  int          t = 0;
  logic [15:0] m_dig = '0;
  logic [3:0]  m_en = '0;
  logic [3:0]  m_bl = '0;
  logic [1:0]  m_br = '0;
  logic        m_ph = 1'b0;
  logic [6:0]  hex_tab [16];
  vec_t        vecs [5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  task automatic step();
    obs_t       e;
    obs_t       g;
    int         slot;
    int         idx;
    int         onl;
    logic       lit;
    logic [3:0] nib;
    if (!rst_n) begin
      e = '{an: 4'hF, sg: 7'h7F, fs: 1'b0};
      t = 0; m_dig = '0; m_en = '0; m_bl = '0; m_br = '0; m_ph = 1'b0;
    end else begin
      slot = t % R;
      idx  = (t / R) % N;
      case (m_br)
        2'd0:    onl = D;
        2'd3:    onl = R;
        default: onl = D + ((R - D) * int'(m_br)) / 4;
      endcase
      nib  = 4'(m_dig >> (4 * idx));
      lit  = (slot >= D) && (slot < onl) && m_en[idx] && !(m_ph && m_bl[idx]);
      e.an = lit ? ~(4'b0001 << idx) : 4'hF;
      e.sg = lit ? ~hex_tab[nib] : 7'h7F;
      e.fs = (slot == R - 1) && (idx == N - 1);
      if (e.fs) begin
        m_dig = digits; m_en = digit_en; m_bl = blink_en; m_br = brightness;
      end
      if (blink_tick) m_ph = ~m_ph;
      t++;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    g = '{an: anode, sg: seg, fs: frame_start};
    e = sb_q.pop_front();
    check("cycle", 32'(g), 32'(e));
    last = g;
    if (g.an != 4'hF) lit_cnt++;
    if (g.fs) fs_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    vecs[0] = '{dg: 16'h1234, en: 4'hF,    br: 2'd3, exp_lit: 28};
    vecs[1] = '{dg: 16'h1234, en: 4'hF,    br: 2'd1, exp_lit: 4};
    vecs[2] = '{dg: 16'h1234, en: 4'hF,    br: 2'd0, exp_lit: 0};
    vecs[3] = '{dg: 16'h1234, en: 4'b1010, br: 2'd3, exp_lit: 14};
    vecs[4] = '{dg: 16'h5678, en: 4'hF,    br: 2'd2, exp_lit: 12};

    // Power-on reset and the reset-state outputs.
    #2 rst_n = 1'b0;
    #1;
    check("reset_anode", 32'(anode), 32'h0000000F);
    check("reset_seg", 32'(seg), 32'h0000007F);
    check("reset_fs", 32'(frame_start), 32'h0);
    run(2);
    rst_n = 1'b1;

    // First frame runs on zero latches and must be dark.
    digits = 16'h1234; digit_en = 4'hF; brightness = 2'd3;
    lit_cnt = 0; fs_cnt = 0;
    run(FRAME);
    check("first_frame_lit", 32'(lit_cnt), 32'd0);
    check("first_frame_fs", 32'(fs_cnt), 32'd1);

    // Table-driven frames: program, let one boundary latch it, measure next frame.
    for (int v = 0; v < 5; v++) begin
      digits = vecs[v].dg; digit_en = vecs[v].en; brightness = vecs[v].br;
      run(FRAME);
      lit_cnt = 0; fs_cnt = 0;
      run(FRAME);
      check("vec_lit", 32'(lit_cnt), 32'(vecs[v].exp_lit));
      check("vec_fs", 32'(fs_cnt), 32'd1);
      $display("vec %0d dig=%h en=%b br=%0d lit=%0d fs=%0d", v, vecs[v].dg,
               vecs[v].en, vecs[v].br, lit_cnt, fs_cnt);
    end

    // Mid-frame digit change does not tear the frame in progress.
    digits = 16'h1234; digit_en = 4'hF; brightness = 2'd3;
    run(FRAME);
    run(18);
    digits = 16'hABCD;
    run(8);
    check("tear_an_d3", 32'(last.an), 32'h7);
    check("tear_seg_d3", 32'(last.sg), 32'h79);
    run(6);
    run(2);
    check("new_seg_d0", 32'(last.sg), 32'h21);
    run(24);
    check("new_seg_d3", 32'(last.sg), 32'h08);
    run(6);
    $display("seq tear: d3 old='1' then 'A' seg=%h", last.sg);

    // Blink digit 0: first tick blanks it, second tick restores it.
    blink_en = 4'b0001;
    run(FRAME);
    blink_tick = 1'b1; step(); blink_tick = 1'b0;
    run(1);
    check("blink_d0_dark", 32'(last.an), 32'hF);
    run(8);
    check("blink_d1_lit", 32'(last.an), 32'hD);
    blink_tick = 1'b1; step(); blink_tick = 1'b0;
    run(21);
    run(2);
    check("blink_d0_back", 32'(last.an), 32'hE);
    check("blink_d0_seg", 32'(last.sg), 32'h21);
    run(30);
    blink_en = 4'b0000;
    $display("seq blink: digit0 restored an=%b", last.an);

    // Asynchronous reset mid-slot, then a clean restart.
    run(3);
    check("pre_reset_lit", 32'(last.an), 32'hE);
    rst_n = 1'b0;
    #1;
    check("async_anode", 32'(anode), 32'hF);
    check("async_seg", 32'(seg), 32'h7F);
    run(2);
    rst_n = 1'b1;
    lit_cnt = 0; fs_cnt = 0;
    run(FRAME);
    check("restart_dark", 32'(lit_cnt), 32'd0);
    check("restart_fs", 32'(fs_cnt), 32'd1);
    lit_cnt = 0; fs_cnt = 0;
    run(FRAME);
    check("restart_lit", 32'(lit_cnt), 32'd28);
    $display("seq reset: restart lit=%0d", lit_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
